seq_detector_moore_param: RTL and testbench
===========================================

Name: seq_detector_moore_param

Overview:
- Parametrised Moore-type serial pattern detector. It is the successor to the fixed 3-bit detectors in the sequential-logic library.
- Detects a PAT_W-bit pattern, set at elaboration, on a 1-bit serial stream qualified by a valid strobe.
- Overlapping or non-overlapping mode is selectable at run time.
- Keeps a saturating match counter for status and debug.
- Sits between a serial deserialiser/sampler and control logic that reacts to framing or sync words.

Parameters:
- PAT_W, 3, pattern length in bits; legal range 2..16.
- PATTERN, 3'b101, pattern to detect, PAT_W bits wide. The MSB is the first bit received.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in  input  1  serial data bit.
- in_valid  input  1  qualifies in. A bit is accepted only on an edge where in_valid=1.
- overlap  input  1  mode select: 1 = overlapping detection, 0 = non-overlapping.
- clr_cnt  input  1  synchronous clear of match_cnt and cnt_sat.
- out  output  1  Moore detect flag; high while the FSM is in the MATCH state.
- state_dbg  output  $clog2(PAT_W+1)  current state index, for debug.
- match_cnt  output  CNT_W  number of matches, saturating.
- cnt_sat  output  1  sticky flag; high once match_cnt has reached its all-ones value.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=0, out=0, state_dbg=0, match_cnt=0, cnt_sat=0.
  - rst has priority over every other input, including in_valid and clr_cnt.
  - Reset applied mid-pattern discards any partial match. No match is credited for bits accepted in the reset cycle.
- States: S0..S(PAT_W).
  - State Sk means the longest suffix of the accepted bits is equal to the first k bits of PATTERN.
  - S(PAT_W) is the MATCH state.
- Transitions happen only on an edge with in_valid=1 and rst=0. With in_valid=0 the state, out and the counter all hold.
- From Sk with k<PAT_W, the next state is the largest j ≤ k+1 such that (prefix of length k, followed by in) ends with the first j bits of PATTERN. This is the KMP failure fallback; it is precomputed at elaboration or in a generate/function.
- From S(PAT_W):
  - overlap=1: compute the next state as above, using the full pattern as the history.
  - overlap=0: treat the history as empty. Next state is S1 if in equals PATTERN[PAT_W-1], otherwise S0.
  - overlap is sampled only on this edge. Changing it at any other time has no effect on the current partial match.
- Output timing:
  - out = (state==S(PAT_W)). It is a pure function of the state register, with no combinational path from in.
  - Latency: out rises on the edge that accepts the final pattern bit, so it is visible in the following cycle.
  - out stays high until the next accepted bit. Across in_valid=0 gaps it holds.
- Match counter:
  - match_cnt increments by 1 on every edge where the next state is S(PAT_W).
  - Back-to-back overlapping matches count individually.
  - At all-ones the counter holds and cnt_sat=1.
- Counter clear: clr_cnt=1 gives match_cnt=0 and cnt_sat=0 on the next edge. If clr_cnt and a match fall on the same edge, clear wins and match_cnt=0.
- Degenerate patterns: all-ones or all-zeros patterns use the same rule. In overlap mode a continuous run of the pattern bit matches on every accepted bit once PAT_W bits have been seen.

Test Plan:
- Defaults (101), overlap=1, in_valid=1, stream 1,0,1,0,1,0,1 → out high in the cycles after bits 3, 5 and 7; match_cnt=3.
- Same stream with overlap=0 → out high after bits 3 and 7 only; match_cnt=2.
- PATTERN=4'b1101, PAT_W=4, stream 1,1,1,0,1,1,0,1 → out high after bit 5 only (bit 8 ends 1101 only with overlap=1). Run both modes: overlap=1 gives match_cnt=2, overlap=0 gives 1. Check state_dbg=2 after bit 3, showing the fallback from "11"+1.
- Defaults, stream 1,0 then in_valid=0 for 5 cycles then 1 → state holds at S2 through the gap; out high after the final bit; a 3-cycle gap after the match keeps out=1.
- Defaults with rst asserted for one cycle after 1,0, then stream 1 → no match (state S1); match_cnt unchanged; all outputs go to reset values on the rst edge.
- CNT_W=2, overlap=1, 9 consecutive matches → match_cnt stops at 3 and cnt_sat=1. Then clr_cnt high on the same edge as a match → match_cnt=0, cnt_sat=0.

Source files
------------

// File: rtl/seq_detector_moore_param.sv
// seq_detector_moore_param
//   Moore serial pattern detector for a PAT_W-bit pattern that is fixed at
//   elaboration. The pattern MSB is the first bit on the wire. State Sk means
//   the longest suffix of the accepted bits matches the first k pattern bits.
//   S(PAT_W) is the MATCH state. The mismatch fallback is a KMP table that is
//   folded to constants at elaboration.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset, priority over everything
//   in         serial data bit
//   in_valid   accept 'in' on this edge; when low, state/out/counter hold
//   overlap    1: overlapping matches, 0: history restarts after a match
//   clr_cnt    synchronous clear of match_cnt / cnt_sat (wins over a match)
//   out        high while in MATCH state (registered, no path from 'in')
//   state_dbg  current state index
//   match_cnt  saturating number of matches
//   cnt_sat    sticky, set once match_cnt reaches all-ones
module seq_detector_moore_param #(
  parameter int              PAT_W   = 3,
  parameter logic [PAT_W-1:0] PATTERN = 3'b101,
  parameter int              CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in,
  input  logic                       in_valid,
  input  logic                       overlap,
  input  logic                       clr_cnt,
  output logic                       out,
  output logic [$clog2(PAT_W+1)-1:0] state_dbg,
  output logic [CNT_W-1:0]           match_cnt,
  output logic                       cnt_sat
);

  localparam int SW = $clog2(PAT_W+1);

  // The state count depends on PAT_W, so states are plain indices, not named
  // enum members.
  typedef logic [SW-1:0] state_t;
  localparam state_t S_IDLE  = '0;
  localparam state_t S_MATCH = state_t'(PAT_W);

  // Next state from Sk on input bit b. The history is the first k pattern bits
  // followed by b, in arrival order. The result is the longest history suffix,
  // capped at PAT_W, that equals a pattern prefix. From Sk with k == PAT_W this
  // gives the overlapping successor.
  function automatic state_t kmp_next(input int k, input logic b);
    logic [PAT_W:0] hist;
    int             best;
    logic           ok;
    hist = '0;
    for (int p = 0; p < PAT_W; p++)
      if (p < k) hist[p] = PATTERN[PAT_W-1-p];
    hist[k] = b;
    best = 0;
    for (int j = 1; j <= PAT_W; j++) begin
      if (j <= k + 1) begin
        ok = 1'b1;
        for (int i = 0; i < j; i++)
          if (hist[k+1-j+i] != PATTERN[PAT_W-1-i]) ok = 1'b0;
        if (ok) best = j;
      end
    end
    return state_t'(best);
  endfunction

  state_t nxt_tbl [PAT_W+1][2];

  for (genvar k = 0; k <= PAT_W; k++) begin : g_k
    for (genvar b = 0; b < 2; b++) begin : g_b
      assign nxt_tbl[k][b] = kmp_next(k, 1'(b));
    end
  end

  state_t             state, state_d;
  logic               hit;
  logic [CNT_W-1:0]   cnt_d;
  logic               sat_d;

  // Next-state logic. After a non-overlapping match, the history is treated as
  // empty, so the next state is the S0 successor. Unreachable encodings above
  // S_MATCH also recover through S0.
  always_comb begin
    state_d = state;
    hit     = 1'b0;
    if (in_valid) begin
      if ((state == S_MATCH && !overlap) || state > S_MATCH)
        state_d = nxt_tbl[0][in];
      else
        state_d = nxt_tbl[state][in];
      hit = (state_d == S_MATCH);
    end
  end

  // Match counter: a clear beats a coincident match, and the count holds at
  // all-ones.
  always_comb begin
    cnt_d = match_cnt;
    sat_d = cnt_sat;
    if (clr_cnt) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else begin
      if (hit && match_cnt != '1) cnt_d = match_cnt + CNT_W'(1);
      sat_d = cnt_sat || (cnt_d == '1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else begin
      state     <= state_d;
      match_cnt <= cnt_d;
      cnt_sat   <= sat_d;
    end
  end

  assign out       = (state == S_MATCH);
  assign state_dbg = state;

endmodule

// File: tb/tb_seq_detector_moore_param.sv
module tb_seq_detector_moore_param;

  logic clk = 1'b0;
  logic rst = 1'b1, in = 1'b0, in_valid = 1'b0, overlap = 1'b1, clr_cnt = 1'b0;

  // u0: default 101 / CNT_W=8, u1: 1101, u2: 101 with CNT_W=2
  logic       o0, o1, o2, sat0, sat1, sat2;
  logic [1:0] sd0, sd2;
  logic [2:0] sd1;
  logic [7:0] mc0, mc1;
  logic [1:0] mc2;

  seq_detector_moore_param u0 (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .overlap(overlap),
    .clr_cnt(clr_cnt), .out(o0), .state_dbg(sd0), .match_cnt(mc0), .cnt_sat(sat0));

  seq_detector_moore_param #(.PAT_W(4), .PATTERN(4'b1101), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .overlap(overlap),
    .clr_cnt(clr_cnt), .out(o1), .state_dbg(sd1), .match_cnt(mc1), .cnt_sat(sat1));

  seq_detector_moore_param #(.PAT_W(3), .PATTERN(3'b101), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .overlap(overlap),
    .clr_cnt(clr_cnt), .out(o2), .state_dbg(sd2), .match_cnt(mc2), .cnt_sat(sat2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    due;
    int    id;
    logic  eo;
    int    es;
    int    ec;
    logic  esat;
    string nm;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Drive one cycle of stimulus on a falling edge. Queue the state expected
  // after the next rising edge.
  task automatic step(input int id, input logic r, input logic v, input logic b,
                      input logic ov, input logic cl, input logic eo,
                      input int es, input int ec, input logic esat, input string nm);
    exp_t e;
    @(negedge clk);
    rst = r; in_valid = v; in = b; overlap = ov; clr_cnt = cl;
    e.due = cyc + 1; e.id = id; e.eo = eo; e.es = es; e.ec = ec; e.esat = esat; e.nm = nm;
    q.push_back(e);
  endtask

  // Monitor: on each falling edge, check every expectation whose edge has passed
  initial begin
    exp_t e;
    logic        ao, asat;
    logic [31:0] as, ac;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        case (e.id)
          0:       begin ao = o0; as = 32'(sd0); ac = 32'(mc0); asat = sat0; end
          1:       begin ao = o1; as = 32'(sd1); ac = 32'(mc1); asat = sat1; end
          default: begin ao = o2; as = 32'(sd2); ac = 32'(mc2); asat = sat2; end
        endcase
        checks++;
        if (ao !== e.eo || as !== 32'(e.es) || ac !== 32'(e.ec) || asat !== e.esat) begin
          errors++;
          $display("FAIL %s cyc=%0d dut=%0d: got out=%0b st=%0d cnt=%0d sat=%0b, want out=%0b st=%0d cnt=%0d sat=%0b",
                   e.nm, cyc, e.id, ao, as, ac, asat, e.eo, e.es, e.ec, e.esat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int m;
    // Test A: 101, overlap, stream 1010101
    step(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, "A_rst");
    step(0, 0, 1, 1, 1, 0, 0, 1, 0, 0, "A_b1");
    step(0, 0, 1, 0, 1, 0, 0, 2, 0, 0, "A_b2");
    step(0, 0, 1, 1, 1, 0, 1, 3, 1, 0, "A_b3");
    step(0, 0, 1, 0, 1, 0, 0, 2, 1, 0, "A_b4");
    step(0, 0, 1, 1, 1, 0, 1, 3, 2, 0, "A_b5");
    step(0, 0, 1, 0, 1, 0, 0, 2, 2, 0, "A_b6");
    step(0, 0, 1, 1, 1, 0, 1, 3, 3, 0, "A_b7");
    // Test B: same stream, non-overlapping
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "B_rst");
    step(0, 0, 1, 1, 0, 0, 0, 1, 0, 0, "B_b1");
    step(0, 0, 1, 0, 0, 0, 0, 2, 0, 0, "B_b2");
    step(0, 0, 1, 1, 0, 0, 1, 3, 1, 0, "B_b3");
    step(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, "B_b4");
    step(0, 0, 1, 1, 0, 0, 0, 1, 1, 0, "B_b5");
    step(0, 0, 1, 0, 0, 0, 0, 2, 1, 0, "B_b6");
    step(0, 0, 1, 1, 0, 0, 1, 3, 2, 0, "B_b7");
    // Test C1: 1101, overlap, stream 11101101
    step(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, "C1_rst");
    step(1, 0, 1, 1, 1, 0, 0, 1, 0, 0, "C1_b1");
    step(1, 0, 1, 1, 1, 0, 0, 2, 0, 0, "C1_b2");
    step(1, 0, 1, 1, 1, 0, 0, 2, 0, 0, "C1_b3_fallback");
    step(1, 0, 1, 0, 1, 0, 0, 3, 0, 0, "C1_b4");
    step(1, 0, 1, 1, 1, 0, 1, 4, 1, 0, "C1_b5");
    step(1, 0, 1, 1, 1, 0, 0, 2, 1, 0, "C1_b6");
    step(1, 0, 1, 0, 1, 0, 0, 3, 1, 0, "C1_b7");
    step(1, 0, 1, 1, 1, 0, 1, 4, 2, 0, "C1_b8");
    // Test C0: 1101, non-overlapping
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, "C0_rst");
    step(1, 0, 1, 1, 0, 0, 0, 1, 0, 0, "C0_b1");
    step(1, 0, 1, 1, 0, 0, 0, 2, 0, 0, "C0_b2");
    step(1, 0, 1, 1, 0, 0, 0, 2, 0, 0, "C0_b3");
    step(1, 0, 1, 0, 0, 0, 0, 3, 0, 0, "C0_b4");
    step(1, 0, 1, 1, 0, 0, 1, 4, 1, 0, "C0_b5");
    step(1, 0, 1, 1, 0, 0, 0, 1, 1, 0, "C0_b6");
    step(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, "C0_b7");
    step(1, 0, 1, 1, 0, 0, 0, 1, 1, 0, "C0_b8");
    // Test D: gaps in in_valid hold state and out
    step(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, "D_rst");
    step(0, 0, 1, 1, 1, 0, 0, 1, 0, 0, "D_b1");
    step(0, 0, 1, 0, 1, 0, 0, 2, 0, 0, "D_b2");
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 1, 0, 0, 2, 0, 0, "D_gap1");
    step(0, 0, 1, 1, 1, 0, 1, 3, 1, 0, "D_b3");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, 1, 3, 1, 0, "D_gap2");
    // Test E: reset mid-pattern discards the partial match
    step(0, 0, 1, 1, 1, 0, 0, 1, 1, 0, "E_b1");
    step(0, 0, 1, 0, 1, 0, 0, 2, 1, 0, "E_b2");
    step(0, 1, 1, 1, 1, 1, 0, 0, 0, 0, "E_rst_mid");
    step(0, 0, 1, 1, 1, 0, 0, 1, 0, 0, "E_post_rst");
    // Test F: CNT_W=2 saturation after 9 overlapping matches, then clear vs match
    step(2, 1, 0, 0, 1, 0, 0, 0, 0, 0, "F_rst");
    for (int i = 1; i <= 19; i++) begin
      m = (i - 1) / 2;
      step(2, 0, 1, logic'(i % 2), 1, 0, logic'(i >= 3 && (i % 2) == 1),
           (i == 1) ? 1 : ((i % 2) == 1 ? 3 : 2), (m > 3) ? 3 : m, logic'(m >= 3), "F_sat_run");
    end
    step(2, 0, 1, 0, 1, 0, 0, 2, 3, 1, "F_hold");
    step(2, 0, 1, 1, 1, 1, 1, 3, 0, 0, "F_clr_vs_match");
    step(2, 0, 1, 0, 1, 0, 0, 2, 0, 0, "F_post_clr0");
    step(2, 0, 1, 1, 1, 0, 1, 3, 1, 0, "F_post_clr1");
    step(2, 0, 0, 0, 1, 0, 1, 3, 1, 0, "F_idle");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations never checked, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
